nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/zigbee_pkg.sv | 21 ++
 rtl/DEMUX184.sv | 21 ++
 rtl/nibble_packer.sv | 101 ++++++++++
 tb/tb_nibble_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared widths and FSM state type for the nibble packer.
// Contents: NIBBLE_W/WORD_W/NB_SLOTS, state_t {FILL, FULL}, slot-to-select helper.
// Pure declarations, no logic.
package zigbee_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 32;
    localparam int NB_SLOTS = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // Map the running slot index to the demux select. In MSN-first mode the
    // first nibble of a word goes to the top of the word.
    function automatic logic [2:0] slot_to_sel(input logic msn_first, input logic [2:0] slot);
        return msn_first ? (3'd7 - slot) : slot;
    endfunction

endpackage

// File: rtl/DEMUX184.sv
// 4-bit 1:8 demultiplexer: places a nibble into one of eight nibble lanes of a 32-bit word.
// Ports: inData (nibble), inSel (lane 0..7, lane 0 = bits [3:0]), outData (word, other lanes 0).
// Purely combinational, no latency, no flow control.
module DEMUX184
    import zigbee_pkg::*;
(
    input  logic [NIBBLE_W-1:0] inData,
    input  logic [2:0]          inSel,
    output logic [WORD_W-1:0]   outData
);

    always_comb begin
        outData = '0;
        for (int i = 0; i < NB_SLOTS; i++) begin
            if (inSel == 3'(i)) begin
                outData[i*NIBBLE_W +: NIBBLE_W] = inData;
            end
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into 32-bit words, with flush to close a partial word.
// Ports: clk/resetn (sync active-low), inData/inValid/inReady/inFlush upstream,
//        outData/outValid/outReady/outCount downstream. Word appears the cycle after the
//        8th accept or the flush; while a word is held, inReady follows outReady.
module nibble_packer
    import zigbee_pkg::*;
#(
    parameter logic MSN_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NIBBLE_W-1:0] inData,
    input  logic                inValid,
    output logic                inReady,
    input  logic                inFlush,
    output logic [WORD_W-1:0]   outData,
    output logic                outValid,
    input  logic                outReady,
    output logic [3:0]          outCount
);

    state_t              state, state_nxt;
    logic [2:0]          slot, slot_nxt;
    logic [WORD_W-1:0]   word, word_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [WORD_W-1:0]   demux_out;
    logic                in_rdy;
    logic                accept;
    logic                take;

    // While a word is held, a nibble can only enter if the word leaves in the
    // same cycle, so input readiness follows outReady. Never depends on inValid.
    assign in_rdy = (state == FILL) || outReady;
    assign accept = inValid && in_rdy;
    assign take   = (state == FULL) && outReady;

    // In FULL the slot counter is always 0, so the demux already targets the
    // first slot of the next word for a take+accept cycle.
    DEMUX184 u_demux (
        .inData  (inData),
        .inSel   (slot_to_sel(MSN_FIRST, slot)),
        .outData (demux_out)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= FILL;
            slot  <= '0;
            word  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            word  <= word_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        word_nxt  = word;
        cnt_nxt   = cnt;
        if (state == FILL) begin
            if (accept) begin
                word_nxt = word | demux_out;
                // A flush riding on an accept closes the word including this nibble.
                if (slot == 3'd7 || inFlush) begin
                    state_nxt = FULL;
                    cnt_nxt   = {1'b0, slot} + 4'd1;
                    slot_nxt  = '0;
                end else begin
                    slot_nxt = slot + 3'd1;
                end
            end else if (inFlush && slot != 3'd0) begin
                state_nxt = FULL;
                cnt_nxt   = {1'b0, slot};
                slot_nxt  = '0;
            end
        end else begin
            // Flush is ignored while holding a word.
            if (take) begin
                state_nxt = FILL;
                cnt_nxt   = '0;
                if (accept) begin
                    word_nxt = demux_out;
                    slot_nxt = 3'd1;
                end else begin
                    word_nxt = '0;
                    slot_nxt = 3'd0;
                end
            end
        end
    end

    assign inReady  = in_rdy;
    assign outValid = (state == FULL);
    assign outData  = word;
    assign outCount = cnt;

endmodule

// File: tb/tb_nibble_packer.sv
module tb_nibble_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  inData;
    logic        inValid;
    logic        inFlush;
    logic        outReady;

    logic        irdy0, ovld0, irdy1, ovld1;
    logic [31:0] od0, od1;
    logic [3:0]  oc0, oc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_packer #(.MSN_FIRST(1'b0)) u_lsn (
        .clk(clk), .resetn(resetn), .inData(inData), .inValid(inValid),
        .inReady(irdy0), .inFlush(inFlush), .outData(od0), .outValid(ovld0),
        .outReady(outReady), .outCount(oc0)
    );

    nibble_packer #(.MSN_FIRST(1'b1)) u_msn (
        .clk(clk), .resetn(resetn), .inData(inData), .inValid(inValid),
        .inReady(irdy1), .inFlush(inFlush), .outData(od1), .outValid(ovld1),
        .outReady(outReady), .outCount(oc1)
    );

    typedef struct {
        logic        vld;
        logic [3:0]  dat;
        logic        fl;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic        chk_dat;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic vld, input logic [3:0] dat, input logic fl,
                                input logic ordy, input logic e_irdy, input logic e_ovld,
                                input logic chk_dat, input logic [31:0] e_d0,
                                input logic [31:0] e_d1, input logic [3:0] e_cnt);
        vec_t v;
        v.vld = vld; v.dat = dat; v.fl = fl; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.chk_dat = chk_dat;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data/count are only meaningful while outValid is expected, unless chk_dat forces a
    // look at the (registered) word, e.g. right after a take+accept.
    task automatic check_outs(input string tag, input logic e_irdy, input logic e_ovld,
                              input logic chk_dat, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [3:0] cnt);
        chk({tag, ".inReady0"}, 32'(irdy0), 32'(e_irdy));
        chk({tag, ".inReady1"}, 32'(irdy1), 32'(e_irdy));
        chk({tag, ".outValid0"}, 32'(ovld0), 32'(e_ovld));
        chk({tag, ".outValid1"}, 32'(ovld1), 32'(e_ovld));
        if (e_ovld || chk_dat) begin
            chk({tag, ".outData0"}, od0, d0);
            chk({tag, ".outData1"}, od1, d1);
        end
        if (e_ovld) begin
            chk({tag, ".outCount0"}, 32'(oc0), 32'(cnt));
            chk({tag, ".outCount1"}, 32'(oc1), 32'(cnt));
        end
    endtask

    task automatic apply(input logic v, input logic [3:0] d, input logic f,
                         input logic r, input logic rn);
        @(negedge clk);
        inValid  = v;
        inData   = d;
        inFlush  = f;
        outReady = r;
        resetn   = rn;
    endtask

    // Reference model state for the random phase.
    logic [3:0]  q[$];
    logic        held;
    logic [31:0] hw0, hw1;
    logic [3:0]  hc;

    initial begin
        logic v, f, r, rn;
        logic [3:0] d;

        resetn = 1'b0; inValid = 1'b0; inData = '0; inFlush = 1'b0; outReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.outValid0", 32'(ovld0), 32'd0);
        chk("reset.outValid1", 32'(ovld1), 32'd0);
        chk("reset.outData0", od0, 32'd0);
        chk("reset.outCount0", 32'(oc0), 32'd0);
        chk("reset.inReady0", 32'(irdy0), 32'd1);
        resetn = 1'b1;

        // Eight back-to-back nibbles, no stall.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 4'(k), 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h87654321, 32'h12345678, 8));
        // A,B,C then flush alone; second flush at empty word emits nothing.
        tbl.push_back(mk(1, 4'hA, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h00000CBA, 32'hABC00000, 3));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h0, 32'h0, 0));
        // Flush coincident with accept at slot 2.
        tbl.push_back(mk(1, 4'h1, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h00000321, 32'h12300000, 3));
        // Flush coincident with the 8th accept equals a normal full word.
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(1, 4'(k), 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h8, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h87654321, 32'h12345678, 8));
        // Backpressure for 5 cycles (flush in FULL ignored), then take + accept of F.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 4'(k), 0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 4'hF, (k == 2) ? 1'b1 : 1'b0, 0, 0, 1, 1,
                             32'h87654321, 32'h12345678, 8));
        tbl.push_back(mk(1, 4'hF, 0, 1, 1, 1, 1, 32'h87654321, 32'h12345678, 8));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 32'h0000000F, 32'hF0000000, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 32'h0000000F, 32'hF0000000, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h0000000F, 32'hF0000000, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].vld, tbl[i].dat, tbl[i].fl, tbl[i].ordy, 1'b1);
            #1;
            check_outs($sformatf("tbl%0d", i), tbl[i].e_irdy, tbl[i].e_ovld, tbl[i].chk_dat,
                       tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_cnt);
        end

        // Reset after 5 nibbles discards the partial word.
        for (int k = 1; k <= 5; k++) begin
            apply(1, 4'(k), 0, 1, 1);
            #1;
            check_outs("rst_fill", 1, 0, 0, 0, 0, 0);
        end
        apply(0, 0, 0, 1, 0);
        #1;
        check_outs("rst_assert", 1, 0, 0, 0, 0, 0);
        begin
            logic [3:0] seq [8];
            seq = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
            for (int k = 0; k < 8; k++) begin
                apply(1, seq[k], 0, 1, 1);
                #1;
                check_outs("rst_refill", 1, 0, (k == 0), 32'h0, 32'h0, 0);
            end
        end
        apply(0, 0, 0, 1, 1);
        #1;
        check_outs("rst_word", 1, 1, 1, 32'h1FEDCBA9, 32'h9ABCDEF1, 8);

        // Randomized traffic against a queue-based model.
        held = 1'b0; hw0 = '0; hw1 = '0; hc = '0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 9) < 7);
            d  = 4'($urandom_range(0, 15));
            f  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 63) != 0);
            apply(v, d, f, r, rn);
            #1;
            check_outs("rnd", held ? r : 1'b1, held, 1'b0, hw0, hw1, hc);
            if (!rn) begin
                q.delete();
                held = 1'b0;
            end else if (held) begin
                if (r) begin
                    held = 1'b0;
                    if (v) q.push_back(d);
                end
            end else begin
                if (v) q.push_back(d);
                if (q.size() == 8 || (f && q.size() > 0)) begin
                    hw0 = '0;
                    hw1 = '0;
                    foreach (q[i]) begin
                        hw0 |= 32'(q[i]) << (4 * i);
                        hw1 |= 32'(q[i]) << (4 * (7 - i));
                    end
                    hc   = 4'(q.size());
                    held = 1'b1;
                    q.delete();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
